// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU beside the single-cycle execute path: stepped shifts, early-exit
// shift-add multiply and fixed-latency restoring divide, with valid/ready and flush.
module alu_seq_unit #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag,
    output logic             div_zero_flag,
    output logic             invalid_flag,
    output logic             busy
);
    localparam int AMT_W = $clog2(WIDTH);
    localparam int CNT_W = AMT_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_MUL, S_DIV, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_SLL = 3'd0, OP_SRL, OP_SRA, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_RSVD
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d, dz_q, dz_d, inv_q, inv_d;

    logic               accept;
    logic [AMT_W-1:0]   in_amt;
    logic [CNT_W-1:0]   shamt;
    logic [WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0] prod_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;

    // Flush wins over a simultaneous request, even in IDLE.
    assign accept = in_valid && (state_q == S_IDLE) && !flush;
    assign in_amt = operand_b[AMT_W-1:0];

    always_comb begin
        shamt = (cnt_q > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : cnt_q;
        case (op_q)
            OP_SLL:  shifted = work_q[WIDTH-1:0] << shamt;
            OP_SRA:  shifted = $signed(work_q[WIDTH-1:0]) >>> shamt;
            default: shifted = work_q[WIDTH-1:0] >> shamt;
        endcase
        prod_sum = acc_q + (b_q[0] ? work_q : '0);
        rem_sh   = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, b_q});
        rem_diff = rem_sh[WIDTH-1:0] - b_q;
    end

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        inv_d    = inv_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d   = op_e'(op_code);
                work_d = {{WIDTH{1'b0}}, operand_a};
                b_d    = operand_b;
                acc_d  = '0;
                cnt_d  = '0;
                ovf_d  = 1'b0;
                dz_d   = 1'b0;
                inv_d  = 1'b0;
                case (op_e'(op_code))
                    OP_SLL, OP_SRL, OP_SRA: begin
                        cnt_d = CNT_W'(in_amt);
                        if (in_amt == '0) begin
                            state_d  = S_DONE;
                            result_d = operand_a;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end
                    OP_MUL, OP_MULHU: begin
                        if (operand_a == '0 || operand_b == '0) begin
                            state_d  = S_DONE;
                            result_d = '0;
                        end else begin
                            state_d = S_MUL;
                        end
                    end
                    OP_DIVU, OP_REMU: begin
                        if (operand_b == '0) begin
                            state_d  = S_DONE;
                            dz_d     = 1'b1;
                            result_d = (op_e'(op_code) == OP_DIVU) ? '1 : operand_a;
                        end else begin
                            state_d = S_DIV;
                            cnt_d   = CNT_W'(WIDTH);
                        end
                    end
                    default: begin
                        state_d  = S_DONE;
                        inv_d    = 1'b1;
                        result_d = '0;
                    end
                endcase
            end
            S_SHIFT: begin
                // cnt_q holds the shift distance still to go.
                work_d[WIDTH-1:0] = shifted;
                cnt_d             = cnt_q - shamt;
                if (cnt_q <= CNT_W'(SHIFT_STEP)) begin
                    state_d  = S_DONE;
                    result_d = shifted;
                end
            end
            S_MUL: begin
                acc_d  = prod_sum;
                work_d = work_q << 1;
                b_d    = b_q >> 1;
                if (b_q[WIDTH-1:1] == '0) begin
                    state_d = S_DONE;
                    if (op_q == OP_MUL) begin
                        result_d = prod_sum[WIDTH-1:0];
                        ovf_d    = |prod_sum[2*WIDTH-1:WIDTH];
                    end else begin
                        result_d = prod_sum[2*WIDTH-1:WIDTH];
                    end
                end
            end
            S_DIV: begin
                // Quotient bits shift in at the bottom of work_q as dividend bits leave the top.
                acc_d[WIDTH-1:0]  = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                work_d[WIDTH-1:0] = {work_q[WIDTH-2:0], rem_ge};
                cnt_d             = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = (op_q == OP_DIVU) ? {work_q[WIDTH-2:0], rem_ge}
                                                 : (rem_ge ? rem_diff : rem_sh[WIDTH-1:0]);
                end
            end
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLL;
            work_q   <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            inv_q    <= inv_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign result        = result_q;
    assign overflow_flag = ovf_q;
    assign div_zero_flag = dz_q;
    assign invalid_flag  = inv_q;

endmodule
